// File: rtl/bridge_top_2ff.sv
// -----------------------------------------------------------------------------
// bridge_top_2ff
//
// Bidirectional single-word transfer bridge between a master port (_m) and a
// slave port (_s). Each direction is an independent channel using a 4-phase
// req/ack handshake. Every crossing control signal passes through a two-flop
// synchronizer, so the two sides can later be moved onto separate clocks.
// The hold register is passed as a plain bus. It is stable whenever req or ack
// is high.
//
// Ports (bridge_top_2ff):
//   clk      in   single clock, rising edge
//   rst_n    in   synchronous active-low reset
//   sdata_m  in   word the master sends toward the slave side
//   vi_m     in   master send request
//   rdata_m  out  last word received from the slave side
//   vo_m     out  one-cycle pulse: rdata_m updated
//   snt_m    out  one-cycle pulse: master transfer complete, channel idle
//   sdata_s, vi_s, rdata_s, vo_s, snt_s: same roles for the slave side
//
// Ports (bridge_chan_2ff, one direction):
//   clk, rst_n  as above
//   sdata_i     word offered by the sending side
//   vi_i        send request from the sending side
//   snt_o       completion pulse back to the sending side
//   rdata_o     word delivered to the receiving side
//   vo_o        delivery pulse on the receiving side
// -----------------------------------------------------------------------------

module bridge_chan_2ff #(
  parameter int DATA_MSB = 31
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_MSB:0] sdata_i,
  input  logic              vi_i,
  output logic              snt_o,
  output logic [DATA_MSB:0] rdata_o,
  output logic              vo_o
);

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_WAIT_ACK_HI = 2'd1,
    S_WAIT_ACK_LO = 2'd2
  } snd_state_e;

  typedef enum logic {
    R_IDLE  = 1'b0,
    R_ACKED = 1'b1
  } rcv_state_e;

  snd_state_e        snd_state_q, snd_state_d;
  logic [DATA_MSB:0] hold_q, hold_d;
  logic              snt_q, snt_d;
  logic              ack_sync1_q, ack_sync2_q;

  rcv_state_e        rcv_state_q, rcv_state_d;
  logic [DATA_MSB:0] rdata_q, rdata_d;
  logic              vo_q, vo_d;
  logic              req_sync1_q, req_sync2_q;

  // req is high exactly while the sender waits for ack to rise; ack is high
  // exactly while the receiver is in ACKED. Both are therefore state decodes
  // of registers and are glitch-free.
  logic              req_s;
  logic              ack_s;

  assign req_s = (snd_state_q == S_WAIT_ACK_HI);
  assign ack_s = (rcv_state_q == R_ACKED);

  // Sender state, hold register, completion pulse and ack synchronizer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      snd_state_q <= S_IDLE;
      hold_q      <= '0;
      snt_q       <= 1'b0;
      ack_sync1_q <= 1'b0;
      ack_sync2_q <= 1'b0;
    end else begin
      snd_state_q <= snd_state_d;
      hold_q      <= hold_d;
      snt_q       <= snt_d;
      ack_sync1_q <= ack_s;
      ack_sync2_q <= ack_sync1_q;
    end
  end

  // Sender next-state: accept in IDLE, drop req on synced ack high, finish on synced ack low.
  always_comb begin
    snd_state_d = snd_state_q;
    hold_d      = hold_q;
    snt_d       = 1'b0;
    case (snd_state_q)
      S_IDLE: begin
        if (vi_i) begin
          hold_d      = sdata_i;
          snd_state_d = S_WAIT_ACK_HI;
        end else begin
          snd_state_d = S_IDLE;
        end
      end
      S_WAIT_ACK_HI: begin
        if (ack_sync2_q) begin
          snd_state_d = S_WAIT_ACK_LO;
        end else begin
          snd_state_d = S_WAIT_ACK_HI;
        end
      end
      S_WAIT_ACK_LO: begin
        if (!ack_sync2_q) begin
          snt_d       = 1'b1;
          snd_state_d = S_IDLE;
        end else begin
          snd_state_d = S_WAIT_ACK_LO;
        end
      end
      default: begin
        snd_state_d = S_IDLE;
      end
    endcase
  end

  // Receiver state, delivered word, delivery pulse and req synchronizer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rcv_state_q <= R_IDLE;
      rdata_q     <= '0;
      vo_q        <= 1'b0;
      req_sync1_q <= 1'b0;
      req_sync2_q <= 1'b0;
    end else begin
      rcv_state_q <= rcv_state_d;
      rdata_q     <= rdata_d;
      vo_q        <= vo_d;
      req_sync1_q <= req_s;
      req_sync2_q <= req_sync1_q;
    end
  end

  // Receiver next-state: capture the hold bus once synced req rises, release ack once it falls.
  always_comb begin
    rcv_state_d = rcv_state_q;
    rdata_d     = rdata_q;
    vo_d        = 1'b0;
    case (rcv_state_q)
      R_IDLE: begin
        if (req_sync2_q) begin
          // hold_q has been stable since req rose two edges ago.
          rdata_d     = hold_q;
          vo_d        = 1'b1;
          rcv_state_d = R_ACKED;
        end else begin
          rcv_state_d = R_IDLE;
        end
      end
      R_ACKED: begin
        if (!req_sync2_q) begin
          rcv_state_d = R_IDLE;
        end else begin
          rcv_state_d = R_ACKED;
        end
      end
      default: begin
        rcv_state_d = R_IDLE;
      end
    endcase
  end

  assign snt_o   = snt_q;
  assign rdata_o = rdata_q;
  assign vo_o    = vo_q;

endmodule

module bridge_top_2ff #(
  parameter int DATA_MSB = 31
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_MSB:0] sdata_m,
  input  logic              vi_m,
  output logic [DATA_MSB:0] rdata_m,
  output logic              vo_m,
  output logic              snt_m,
  input  logic [DATA_MSB:0] sdata_s,
  input  logic              vi_s,
  output logic [DATA_MSB:0] rdata_s,
  output logic              vo_s,
  output logic              snt_s
);

  // Master-to-slave channel.
  bridge_chan_2ff #(.DATA_MSB(DATA_MSB)) u_m2s (
    .clk     (clk),
    .rst_n   (rst_n),
    .sdata_i (sdata_m),
    .vi_i    (vi_m),
    .snt_o   (snt_m),
    .rdata_o (rdata_s),
    .vo_o    (vo_s)
  );

  // Slave-to-master channel.
  bridge_chan_2ff #(.DATA_MSB(DATA_MSB)) u_s2m (
    .clk     (clk),
    .rst_n   (rst_n),
    .sdata_i (sdata_s),
    .vi_i    (vi_s),
    .snt_o   (snt_s),
    .rdata_o (rdata_m),
    .vo_o    (vo_m)
  );

endmodule

// File: tb/tb_bridge_top_2ff.sv
// -----------------------------------------------------------------------------
// tb_bridge_top_2ff
//
// Self-checking bench for bridge_top_2ff. A transaction-level reference model
// records each channel's accept edge and word. From the accept edge it predicts
// the delivery pulse three edges later and the completion pulse twelve edges
// later. Outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------

module tb_bridge_top_2ff;

  localparam int DATA_MSB = 31;
  localparam int VW = 2 * (DATA_MSB + 1) + 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DATA_MSB:0] sdata_m = '0;
  logic              vi_m = 1'b0;
  logic [DATA_MSB:0] rdata_m;
  logic              vo_m;
  logic              snt_m;
  logic [DATA_MSB:0] sdata_s = '0;
  logic              vi_s = 1'b0;
  logic [DATA_MSB:0] rdata_s;
  logic              vo_s;
  logic              snt_s;

  bridge_top_2ff #(.DATA_MSB(DATA_MSB)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sdata_m (sdata_m),
    .vi_m    (vi_m),
    .rdata_m (rdata_m),
    .vo_m    (vo_m),
    .snt_m   (snt_m),
    .sdata_s (sdata_s),
    .vi_s    (vi_s),
    .rdata_s (rdata_s),
    .vo_s    (vo_s),
    .snt_s   (snt_s)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model. Channel 0 carries data M->S and channel 1 carries data S->M.
  int                edge_n = 0;
  int                acc_edge [2];
  logic [DATA_MSB:0] word     [2];
  logic [DATA_MSB:0] m_rdata  [2];
  logic              m_vo     [2];
  logic              m_snt    [2];

  function automatic logic [VW-1:0] exp_vec();
    return {m_rdata[1], m_vo[1], m_snt[0], m_rdata[0], m_vo[0], m_snt[1]};
  endfunction

  function automatic logic [VW-1:0] got_vec();
    return {rdata_m, vo_m, snt_m, rdata_s, vo_s, snt_s};
  endfunction

  task automatic chan_model(input int c, input logic vi, input logic [DATA_MSB:0] d);
    m_vo[c]  = 1'b0;
    m_snt[c] = 1'b0;
    if (acc_edge[c] < 0) begin
      if (vi) begin
        acc_edge[c] = edge_n;
        word[c]     = d;
      end
    end else begin
      if (edge_n == acc_edge[c] + 3) begin
        m_vo[c]    = 1'b1;
        m_rdata[c] = word[c];
      end
      if (edge_n == acc_edge[c] + 12) begin
        m_snt[c]    = 1'b1;
        acc_edge[c] = -1;
      end
    end
  endtask

  // Advance one clock edge. The inputs the DUT samples on that edge also
  // advance the model.
  task automatic step();
    logic              r, vm, vs;
    logic [DATA_MSB:0] dm, ds;
    r = rst_n; vm = vi_m; vs = vi_s; dm = sdata_m; ds = sdata_s;
    @(posedge clk);
    edge_n++;
    if (!r) begin
      for (int c = 0; c < 2; c++) begin
        acc_edge[c] = -1;
        m_rdata[c]  = '0;
        m_vo[c]     = 1'b0;
        m_snt[c]    = 1'b0;
      end
    end else begin
      chan_model(0, vm, dm);
      chan_model(1, vs, ds);
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; vi_m = 1'b0; vi_s = 1'b0;
    for (int k = 0; k < 2; k++) step();
    vectors++;
    if (got_vec() !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h required 0", got_vec());
    end
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      vectors++;
      if (got_vec() !== '0) begin
        miscompares++;
        $display("FAIL reset_idle cyc%0d: got %h required 0", k, got_vec());
      end
    end
  endtask

  task automatic test_single();
    int vo_at = -1, snt_at = -1, stray = 0;
    sdata_m = 32'h1; vi_m = 1'b1;
    for (int k = 0; k < 16; k++) begin
      step();
      vi_m = 1'b0;
      if (vo_s)  vo_at  = (vo_at < 0) ? k : 99;
      if (snt_m) snt_at = (snt_at < 0) ? k : 99;
      if (vo_m || snt_s) stray++;
      vectors++;
      if (got_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL single cyc%0d: got %h required %h", k, got_vec(), exp_vec());
      end
    end
    vectors++;
    if (vo_at !== 3 || snt_at !== 12 || stray !== 0 || rdata_s !== 32'h1) begin
      miscompares++;
      $display("FAIL single_timing: vo@%0d snt@%0d stray=%0d rdata_s=%h required vo@3 snt@12 stray=0 rdata_s=1",
               vo_at, snt_at, stray, rdata_s);
    end
  endtask

  task automatic test_simultaneous();
    int vo_err = 0, snt_err = 0;
    sdata_m = 32'h1; sdata_s = 32'h1; vi_m = 1'b1; vi_s = 1'b1;
    for (int k = 0; k < 16; k++) begin
      step();
      vi_m = 1'b0; vi_s = 1'b0;
      if ((vo_m !== (k == 3)) || (vo_s !== (k == 3))) vo_err++;
      if ((snt_m !== (k == 12)) || (snt_s !== (k == 12))) snt_err++;
      vectors++;
      if (got_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL simultaneous cyc%0d: got %h required %h", k, got_vec(), exp_vec());
      end
    end
    vectors++;
    if (vo_err != 0 || snt_err != 0 || rdata_m !== 32'h1 || rdata_s !== 32'h1) begin
      miscompares++;
      $display("FAIL simultaneous_pulses: vo_err=%0d snt_err=%0d rdata_m=%h rdata_s=%h required 0 0 1 1",
               vo_err, snt_err, rdata_m, rdata_s);
    end
  endtask

  task automatic test_busy_ignore();
    int n_vo = 0;
    logic [DATA_MSB:0] first_w = '0, second_w = '0;
    sdata_m = 32'hA5; vi_m = 1'b1;
    for (int k = 0; k < 30; k++) begin
      step();
      // Hold vi_m high with new data through the busy window and up to E13.
      if (k < 13) begin vi_m = 1'b1; sdata_m = 32'h3C; end
      else        begin vi_m = 1'b0; sdata_m = $urandom; end
      if (vo_s) begin
        n_vo++;
        if (n_vo == 1) first_w = rdata_s;
        else second_w = rdata_s;
      end
      vectors++;
      if (got_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL busy cyc%0d: got %h required %h", k, got_vec(), exp_vec());
      end
    end
    vectors++;
    if (n_vo != 2 || first_w !== 32'hA5 || second_w !== 32'h3C) begin
      miscompares++;
      $display("FAIL busy_words: vo_count=%0d first=%h second=%h required 2 a5 3c", n_vo, first_w, second_w);
    end
  endtask

  task automatic test_back_to_back();
    int last_vo = -1, n_vo = 0, gap_err = 0;
    vi_s = 1'b1; sdata_s = $urandom;
    for (int k = 0; k < 70; k++) begin
      step();
      sdata_s = $urandom;
      if (vo_m) begin
        if (last_vo >= 0 && k - last_vo != 13) gap_err++;
        last_vo = k; n_vo++;
      end
      vectors++;
      if (got_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL back_to_back cyc%0d: got %h required %h", k, got_vec(), exp_vec());
      end
    end
    vi_s = 1'b0;
    // The first accept happens on step 0, so vo_m is expected at 3, 16, 29, 42, 55 and 68.
    vectors++;
    if (n_vo != 6 || gap_err != 0) begin
      miscompares++;
      $display("FAIL back_to_back_rate: vo_count=%0d gap_err=%0d required 6 0", n_vo, gap_err);
    end
    for (int k = 0; k < 14; k++) step();
  endtask

  task automatic test_reset_mid();
    int n_pulse = 0, vo_at = -1;
    sdata_m = $urandom; vi_m = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      vi_m = 1'b0;
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    vectors++;
    if (got_vec() !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_outputs: got %h required 0", got_vec());
    end
    for (int k = 0; k < 16; k++) begin
      step();
      if (vo_m || vo_s || snt_m || snt_s) n_pulse++;
      vectors++;
      if (got_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL reset_mid_after cyc%0d: got %h required %h", k, got_vec(), exp_vec());
      end
    end
    vectors++;
    if (n_pulse != 0) begin
      miscompares++;
      $display("FAIL reset_mid_pulses: got %0d pulses required 0", n_pulse);
    end
    sdata_m = 32'h5A5A_0001; vi_m = 1'b1;
    for (int k = 0; k < 14; k++) begin
      step();
      vi_m = 1'b0;
      if (vo_s && vo_at < 0) vo_at = k;
    end
    vectors++;
    if (vo_at != 3 || rdata_s !== 32'h5A5A_0001) begin
      miscompares++;
      $display("FAIL reset_mid_fresh: vo@%0d rdata_s=%h required vo@3 5a5a0001", vo_at, rdata_s);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      vi_m = ($urandom_range(0, 3) == 0);
      vi_s = ($urandom_range(0, 2) == 0);
      sdata_m = $urandom;
      sdata_s = $urandom;
      step();
      vectors++;
      if (got_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL random cyc%0d: got %h required %h", k, got_vec(), exp_vec());
      end
    end
    vi_m = 1'b0; vi_s = 1'b0;
  endtask

  initial begin
    for (int c = 0; c < 2; c++) begin
      acc_edge[c] = -1; word[c] = '0; m_rdata[c] = '0; m_vo[c] = 1'b0; m_snt[c] = 1'b0;
    end
    test_reset();
    test_single();
    test_simultaneous();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
